// File: rtl/muxn_stage.sv
// muxn_stage: N-way WIDTH-bit selector feeding a one-entry registered,
// valid/ready handshaked output stage.
// Build option MUXN_RR_EN: adds the rr_mode port and the ptr register for
// round-robin arbitration. Without it the block always uses direct select.
module muxn_stage #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   select,
`ifdef MUXN_RR_EN
   input  logic               rr_mode,
`endif
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   // Unflattened view of the input words, one per lane
   logic [WIDTH-1:0] in_word [N];
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign in_word[i] = in_data[i*WIDTH +: WIDTH];
   end

   logic             load_ok;
   logic             dir_ok;
   logic             rr;
   logic [SEL_W-1:0] sel_idx;
   logic             sel_ok;
   logic             xfer;
   logic [WIDTH-1:0] chosen;

   // Output entry can accept a new word when empty or draining this cycle
   assign load_ok = !out_valid || out_ready;
   assign dir_ok  = int'(select) < N;

`ifdef MUXN_RR_EN
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_found;

   assign rr = rr_mode;

   // Round-robin grant: first valid lane scanning from ptr, wrapping mod N
   always_comb begin
      int j;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!gnt_found && in_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = SEL_W'(j);
         end
      end
   end

   // Priority pointer advances past the granted lane on each RR transfer
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (rr && xfer)
         ptr <= (int'(gnt_idx) == N-1) ? '0 : SEL_W'(int'(gnt_idx) + 1);
   end

   // Pick the source index and whether it is eligible this cycle
   always_comb begin
      sel_idx = rr ? gnt_idx : select;
      sel_ok  = rr ? gnt_found : dir_ok;
   end
`else
   assign rr = 1'b0;

   // Direct mode only: the select input names the source
   always_comb begin
      sel_idx = select;
      sel_ok  = dir_ok && !rr;
   end
`endif

   // At most one ready bit, only toward the chosen lane; held low in reset
   always_comb begin
      for (int i = 0; i < N; i++)
         in_ready[i] = !reset && load_ok && sel_ok && (sel_idx == SEL_W'(i));
   end

   assign xfer = |(in_valid & in_ready);

   // Data mux over the lanes; only consumed when a transfer happens
   always_comb begin
      chosen = '0;
      for (int i = 0; i < N; i++)
         if (sel_idx == SEL_W'(i)) chosen = in_word[i];
   end

   // One-entry output register with simultaneous drain and refill
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= chosen;
         out_sel   <= sel_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_muxn_stage.sv
// tb_muxn_stage: table-driven checks of direct-mode streaming and
// backpressure, out-of-range select on an N=3 instance, and (when built
// with MUXN_RR_EN) round-robin fairness and reset during RR.
module tb_muxn_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [1:0]   select;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;
   logic         out_valid;
   logic         out_ready;
`ifdef MUXN_RR_EN
   logic         rr_mode;
`endif

   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [1:0]   select3;
   logic [31:0]  out_data3;
   logic [1:0]   out_sel3;
   logic         out_valid3;
   logic         out_ready3;
`ifdef MUXN_RR_EN
   logic         rr_mode3;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   muxn_stage #(.WIDTH(32), .N(4), .SEL_W(2)) u4 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .select(select),
`ifdef MUXN_RR_EN
      .rr_mode(rr_mode),
`endif
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
      .out_ready(out_ready));

   muxn_stage #(.WIDTH(32), .N(3), .SEL_W(2)) u3 (
      .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .select(select3),
`ifdef MUXN_RR_EN
      .rr_mode(rr_mode3),
`endif
      .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
      .out_ready(out_ready3));

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic [31:0] base;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_od;
      logic [1:0]  exp_os;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_data(input logic [31:0] base);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic ov, input logic [31:0] od,
                          input logic [1:0] os);
      chk({name, ".out_valid"}, 64'(out_valid), 64'(ov));
      chk({name, ".out_data"},  64'(out_data),  64'(od));
      chk({name, ".out_sel"},   64'(out_sel),   64'(os));
   endtask

   initial begin
      // lane i carries base + i; expected data = base + selected lane
      vt[0]  = '{2'd1, 4'b0010, 32'h11111110, 1'b1, 4'b0010, 1'b1, 32'h11111111, 2'd1};
      vt[1]  = '{2'd1, 4'b0010, 32'h22222221, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1};
      vt[2]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 4'b0010, 1'b0, 32'h22222222, 2'd1};
      vt[3]  = '{2'd3, 4'b1000, 32'hDEADBEEC, 1'b0, 4'b1000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[4]  = '{2'd0, 4'b1111, 32'h01010101, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[5]  = '{2'd2, 4'b1111, 32'h02020202, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[6]  = '{2'd1, 4'b1111, 32'h03030303, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[7]  = '{2'd3, 4'b1111, 32'h04040404, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[8]  = '{2'd0, 4'b1111, 32'h05050505, 1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd3};
      vt[9]  = '{2'd2, 4'b0100, 32'hCAFEF00C, 1'b1, 4'b0100, 1'b1, 32'hCAFEF00E, 2'd2};
      vt[10] = '{2'd0, 4'b0001, 32'h5A5A5A5A, 1'b1, 4'b0001, 1'b1, 32'h5A5A5A5A, 2'd0};
      vt[11] = '{2'd0, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 32'h5A5A5A5A, 2'd0};
      vt[12] = '{2'd2, 4'b0000, 32'h00000000, 1'b1, 4'b0100, 1'b0, 32'h5A5A5A5A, 2'd0};

      // Reset with every input valid
      reset = 1'b1; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      set_data(32'h77777770);
`ifdef MUXN_RR_EN
      rr_mode = 1'b0; rr_mode3 = 1'b0;
`endif
      select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
      for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hA0 + 32'(i);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("reset.in_ready", 64'(in_ready), 64'h0);
         tick;
         chk_out("reset", 1'b0, 32'h0, 2'd0);
         chk("reset.u3_valid", 64'(out_valid3), 64'h0);
      end

      // First cycle out of reset: ready follows load_ok immediately
      reset = 1'b0;
      #1;
      chk("release.in_ready", 64'(in_ready), 64'h4);
      tick;
      chk_out("release", 1'b1, 32'h77777772, 2'd2);

      // Direct stream, drain, backpressure, refill
      for (int r = 0; r < 13; r++) begin
         select = vt[r].sel; in_valid = vt[r].vld; out_ready = vt[r].ordy;
         set_data(vt[r].base);
         #1;
         chk($sformatf("vec%0d.in_ready", r), 64'(in_ready), 64'(vt[r].exp_rdy));
         chk($sformatf("vec%0d.u3_ready", r), 64'(in_ready3), 64'h0);
         tick;
         chk_out($sformatf("vec%0d", r), vt[r].exp_ov, vt[r].exp_od, vt[r].exp_os);
         chk($sformatf("vec%0d.u3_valid", r), 64'(out_valid3), 64'h0);
      end

      // N=3 instance: an in-range select works after the out-of-range run
      select3 = 2'd2;
      #1;
      chk("u3.in_ready", 64'(in_ready3), 64'h4);
      tick;
      chk("u3.out_valid", 64'(out_valid3), 64'h1);
      chk("u3.out_data", 64'(out_data3), 64'hA2);
      chk("u3.out_sel", 64'(out_sel3), 64'h2);

`ifdef MUXN_RR_EN
      begin
         logic [1:0] seq [12];
         logic [3:0] vl  [12];
         seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
         vl  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'hA, 4'hA, 4'hF, 4'hF, 4'hF, 4'hF};
         rr_mode = 1'b1; out_ready = 1'b1; set_data(32'h00000100);
         for (int g = 0; g < 10; g++) begin
            in_valid = vl[g];
            #1;
            chk($sformatf("rr%0d.in_ready", g), 64'(in_ready), 64'(4'b0001 << seq[g]));
            tick;
            chk_out($sformatf("rr%0d", g), 1'b1, 32'h100 + 32'(seq[g]), seq[g]);
         end
         // Reset while a word is held: word discarded, ptr back to 0
         reset = 1'b1; in_valid = 4'hF;
         #1;
         chk("rrrst.in_ready", 64'(in_ready), 64'h0);
         tick;
         chk_out("rrrst", 1'b0, 32'h0, 2'd0);
         reset = 1'b0;
         #1;
         chk("rrpost.in_ready", 64'(in_ready), 64'h1);
         tick;
         chk_out("rrpost", 1'b1, 32'h100, 2'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muxn_stage.md
# muxn_stage

Parametrised N-way, WIDTH-bit selector with a registered, handshaked output stage. It generalises the datapath's fixed 4:1 32-bit combinational operand/PC-source muxes. Producers present words with valid/ready. The block picks one of them by an explicit select or, when compiled in, by round-robin arbitration. The chosen word is held in a single output register until the consumer takes it. It sits between multi-source producers (PC sources, writeback sources, debug/bus injectors) and a stallable consumer stage.

## Interface
Parameters:
- WIDTH, 32: data width per input.
- N, 4: number of inputs, 2 or more.
- SEL_W, 2: select width; N <= 2**SEL_W required.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  **one clock; reset is synchronous and active-high**, sampled on rising clk.
- in_data  input  N*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-input valid.
- in_ready  output  N  per-input ready; transfer on input i when in_valid[i] && in_ready[i].
- select  input  SEL_W  input index used in direct mode.
- rr_mode  input  1  1 = round-robin mode, 0 = direct mode. Present only with MUXN_RR_EN.
- out_data  output  WIDTH  held word.
- out_sel  output  SEL_W  index of the input that supplied out_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.

## Operation
- Output stage: one entry. load_ok = !out_valid || out_ready, which allows simultaneous drain and refill.
- Direct mode:
  - in_ready[i] = load_ok && (i == select) && (select < N). Ready does not depend on in_valid.
  - If select >= N, all in_ready are 0 and nothing loads.
- Round-robin mode:
  - Register ptr[SEL_W-1:0] gives the highest-priority index.
  - grant = first i with in_valid[i] set, scanning ptr, ptr+1, … wrapping modulo N.
  - in_ready[grant] = load_ok. All other in_ready bits are 0. If no input is valid, all in_ready are 0.
  - On a transfer, ptr <= (grant == N-1) ? 0 : grant+1. Otherwise ptr holds.
- On an input transfer: out_data <= chosen word, out_sel <= chosen index, out_valid <= 1.
- On an output transfer with no input transfer: out_valid <= 0. out_data and out_sel hold their last values.
- While out_valid && !out_ready: out_data, out_sel and out_valid stay stable, whatever happens to select, rr_mode, in_data or in_valid.
- Changing rr_mode takes effect on the next evaluated cycle. ptr is kept across mode changes.
- Never more than one in_ready bit is high in a cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=all 0 during reset cycles.
- Reset mid-operation discards any held word. There is no output transfer in the reset cycle.
- Latency: input transfer in cycle t gives out_valid=1 with that data in cycle t+1.
- Throughput: 1 word/cycle sustained while out_ready=1.
- in_ready and grant are combinational from in_valid, select, rr_mode, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- The first cycle after reset deasserts: in_ready follows load_ok=1.

## Configuration
- MUXN_RR_EN defined:
  - rr_mode port and ptr register are present.
  - Round-robin logic is compiled in.
- MUXN_RR_EN undefined:
  - No rr_mode port and no ptr register.
  - The block always operates in direct mode.
  - Port list is otherwise identical.

## Test plan
- Reset: assert reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout. Then release; direct select=2 -> in_ready=4'b0100 on the first cycle.
- Direct stream: N=4, select=1, in_valid[1]=1, data 0x11111111 then 0x22222222, out_ready=1 -> out_data is 0x11111111 then 0x22222222 on consecutive cycles, out_sel=1, no bubbles.
- Backpressure: load 0xDEADBEEF, hold out_ready=0 for 5 cycles while toggling select and in_data -> out_data=0xDEADBEEF stable, out_valid=1, in_ready=0. The first cycle with out_ready=1 loads the next word with no bubble.
- Out-of-range select: N=3, SEL_W=2, select=3, all in_valid=1 -> in_ready=0, out_valid stays 0.
- Round-robin fairness (MUXN_RR_EN): rr_mode=1, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0,1,2,3,0. With in_valid=4'b1010 from ptr=0 -> grants 1,3,1,3.
- Reset mid-RR: after grants 0,1, assert reset with out_valid=1 -> out_valid=0 next cycle, ptr=0; the next grant with in_valid=4'b1111 is input 0.
